// File: rtl/prog_loader.sv
// Boot-time program loader: accepts a framed instruction stream (length, N words, XOR checksum),
// writes it into program memory and releases the CPU only after the checksum verifies.
module prog_loader #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 5,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  output logic                 cpu_run,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_SIZE:0]   words_loaded
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHECK, S_RUN, S_ERROR} state_t;

  state_t               state_q;
  logic [ADDR_SIZE-1:0] len_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [ADDR_SIZE-1:0] mem_addr_q;
  logic [DATA_SIZE-1:0] csum_q;
  logic [DATA_SIZE-1:0] mem_wdata_q;
  logic [TW-1:0]        tmo_q;
  logic [ADDR_SIZE:0]   wl_q;
  logic                 mem_we_q;
  logic                 cpu_run_q;
  logic                 done_q;
  logic                 err_q;
  logic                 xfer;
  logic                 tmo_hit;

  assign in_ready     = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign busy         = in_ready;
  assign xfer         = in_valid & in_ready;
  // The cycle that would bring the idle count up to TIMEOUT is the one that fails.
  assign tmo_hit      = (tmo_q == TW'(TIMEOUT - 1));

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_run      = cpu_run_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      csum_q      <= '0;
      mem_wdata_q <= '0;
      tmo_q       <= '0;
      wl_q        <= '0;
      mem_we_q    <= 1'b0;
      cpu_run_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;

      // Idle watchdog while the stream is open; a transfer always beats the limit.
      if (in_ready) begin
        if (xfer) begin
          tmo_q <= '0;
        end else if (tmo_hit) begin
          state_q <= S_ERROR;
          err_q   <= 1'b1;
          done_q  <= 1'b0;
          tmo_q   <= '0;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end

      case (state_q)
        S_IDLE, S_RUN, S_ERROR: begin
          if (start) begin
            state_q   <= S_LEN;
            tmo_q     <= '0;
            cpu_run_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        S_LEN: begin
          if (xfer) begin
            len_q   <= in_data[ADDR_SIZE-1:0];
            addr_q  <= '0;
            csum_q  <= '0;
            wl_q    <= '0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= in_data;
            csum_q      <= csum_q ^ in_data;
            wl_q        <= wl_q + (ADDR_SIZE + 1)'(1);
            addr_q      <= addr_q + ADDR_SIZE'(1);
            if (addr_q == len_q) begin
              state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (xfer) begin
            if (in_data == csum_q) begin
              state_q   <= S_RUN;
              cpu_run_q <= 1'b1;
              done_q    <= 1'b1;
              err_q     <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              done_q  <= 1'b0;
              err_q   <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboarded memory writes plus per-scenario status checks.
module tb_prog_loader;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [5:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [5:0] mem_wdata;
  logic       cpu_run;
  logic       busy;
  logic       done;
  logic       err;
  logic [5:0] words_loaded;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0] exp_q[$];
  logic [5:0]  prog [0:31];

  prog_loader #(.DATA_SIZE(6), .ADDR_SIZE(5), .TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // status = {in_ready, busy, cpu_run, done, err}
  function automatic logic [4:0] status();
    return {in_ready, busy, cpu_run, done, err};
  endfunction

  // Scoreboard: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (rstn && mem_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          n_bad++;
          $display("FAIL wr_data: got addr=%0d data=%h, required addr=%0d data=%h",
                   mem_addr, mem_wdata, e[10:6], e[5:0]);
        end else begin
          $display("wr addr=%0d data=%h", mem_addr, mem_wdata);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present a word and hold it until it is accepted; returns #1 after the transfer edge.
  task automatic send_word(input logic [5:0] w);
    int n;
    n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 20 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic stream(input int n, input logic [5:0] csum, input int gap);
    pulse_start();
    send_word(6'(n - 1));
    for (int i = 0; i < n; i++) begin
      repeat (gap) begin @(posedge clk); #1; end
      exp_q.push_back({5'(i), prog[i]});
      send_word(prog[i]);
      n_cmp++;
      if (mem_we !== 1'b1) begin
        n_bad++;
        $display("FAIL wr_strobe: mem_we=%b after word %0d, required 1", mem_we, i);
      end
    end
    repeat (gap) begin @(posedge clk); #1; end
    send_word(csum);
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    #3;
    n_cmp++;
    if ({status(), mem_we, mem_addr, mem_wdata, words_loaded} !== 23'd0) begin
      n_bad++;
      $display("FAIL reset: status=%b we=%b addr=%h wdata=%h wl=%0d, required all 0",
               status(), mem_we, mem_addr, mem_wdata, words_loaded);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (status() !== 5'b00000) begin
      n_bad++;
      $display("FAIL idle: status=%b, required 00000", status());
    end
  endtask

  task automatic test_nominal();
    prog[0] = 6'h11; prog[1] = 6'h22; prog[2] = 6'h05;
    stream(3, 6'h36, 0);
    n_cmp++;
    if (status() !== 5'b00110 || words_loaded !== 6'd3) begin
      n_bad++;
      $display("FAIL nominal: status=%b wl=%0d, required 00110 wl=3", status(), words_loaded);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL nominal_writes: %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_bad_checksum();
    stream(3, 6'h00, 0);
    n_cmp++;
    if (status() !== 5'b00001 || words_loaded !== 6'd3) begin
      n_bad++;
      $display("FAIL bad_csum: status=%b wl=%0d, required 00001 wl=3", status(), words_loaded);
    end
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if (status() !== 5'b00001) begin
      n_bad++;
      $display("FAIL err_hold: status=%b, required 00001", status());
    end
    pulse_start();
    n_cmp++;
    if (status() !== 5'b11000) begin
      n_bad++;
      $display("FAIL err_restart: status=%b, required 11000", status());
    end
  endtask

  task automatic test_gaps();
    stream(3, 6'h36, 3);
    n_cmp++;
    if (status() !== 5'b00110 || words_loaded !== 6'd3) begin
      n_bad++;
      $display("FAIL gaps: status=%b wl=%0d, required 00110 wl=3", status(), words_loaded);
    end
  endtask

  task automatic test_timeout();
    pulse_start();
    send_word(6'h01);
    exp_q.push_back({5'd0, 6'h0A});
    send_word(6'h0A);
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (err !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_early: err=%b in_ready=%b after 3 idle, required err=0 in_ready=1", err, in_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (status() !== 5'b00001 || words_loaded !== 6'd1) begin
      n_bad++;
      $display("FAIL tmo: status=%b wl=%0d after 4 idle, required 00001 wl=1", status(), words_loaded);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 32; i++) prog[i] = 6'(i);
    stream(32, 6'h00, 0);
    n_cmp++;
    if (status() !== 5'b00110 || words_loaded !== 6'd32) begin
      n_bad++;
      $display("FAIL full: status=%b wl=%0d, required 00110 wl=32", status(), words_loaded);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL full_writes: %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    n_cmp++;
    if (status() !== 5'b11000) begin
      n_bad++;
      $display("FAIL reload: status=%b, required 11000", status());
    end
    send_word(6'h02);
    exp_q.push_back({5'd0, 6'h11});
    send_word(6'h11);
    pulse_start();
    n_cmp++;
    if (status() !== 5'b11000) begin
      n_bad++;
      $display("FAIL start_in_data: status=%b, required 11000", status());
    end
    exp_q.push_back({5'd1, 6'h22});
    send_word(6'h22);
    exp_q.push_back({5'd2, 6'h05});
    send_word(6'h05);
    send_word(6'h36);
    n_cmp++;
    if (status() !== 5'b00110 || words_loaded !== 6'd3) begin
      n_bad++;
      $display("FAIL reload_run: status=%b wl=%0d, required 00110 wl=3", status(), words_loaded);
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    send_word(6'h02);
    exp_q.push_back({5'd0, 6'h11});
    send_word(6'h11);
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({status(), mem_we, mem_addr, mem_wdata, words_loaded} !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_mid: status=%b we=%b addr=%h wdata=%h wl=%0d, required all 0",
               status(), mem_we, mem_addr, mem_wdata, words_loaded);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (status() !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_idle: status=%b, required 00000", status());
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_gaps();
    test_timeout();
    test_full();
    test_back_to_back();
    test_reset_mid_load();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
